// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings,
// RV32 opcode constants and the register-index width.
package pipe_ctrl_pkg;

    localparam int REGW = 5;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        MWAIT  = 2'd2,
        REDIR  = 2'd3
    } ctrl_state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-controller signal bundle: hazard sources in, stage enables,
// performance counters and debug state out.
interface pipe_hazard_ctrl_if #(
    parameter int N    = 32,
    parameter int REGW = 5,
    parameter int CNTW = 16
);
    logic [N-1:0]    id_instr;
    logic            ex_memread;
    logic [REGW-1:0] ex_rd;
    logic            ex_branch_taken;
    logic            dmem_busy;
    logic            imem_valid;

    logic            pc_write;
    logic            ifid_write;
    logic            ifid_flush;
    logic            idex_bubble;
    logic            exmem_hold;
    logic [CNTW-1:0] stall_cnt;
    logic [CNTW-1:0] flush_cnt;
    logic [1:0]      state;

    modport master (
        output id_instr, ex_memread, ex_rd, ex_branch_taken, dmem_busy, imem_valid,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold,
        input  stall_cnt, flush_cnt, state
    );

    modport slave (
        input  id_instr, ex_memread, ex_rd, ex_branch_taken, dmem_busy, imem_valid,
        output pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold,
        output stall_cnt, flush_cnt, state
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_decode.sv
// Load-use hazard detect: does the load in EX write a register that the
// instruction in ID actually reads?
module hazard_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int N    = 32,
    parameter int REGW = pipe_ctrl_pkg::REGW
) (
    input  logic [N-1:0]    id_instr,
    input  logic            ex_memread,
    input  logic [REGW-1:0] ex_rd,
    output logic            lu
);
    logic [6:0]      opcode;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic            use_rs1;
    logic            use_rs2;
    logic            unused_bits;

    assign opcode = id_instr[6:0];
    assign rs1    = id_instr[19:15];
    assign rs2    = id_instr[24:20];

    assign use_rs1 = (opcode != OP_LUI) && (opcode != OP_AUIPC) && (opcode != OP_JAL);
    assign use_rs2 = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

    // x0 is never a real dependency.
    assign lu = ex_memread && (ex_rd != '0) &&
                ((use_rs1 && (ex_rd == rs1)) || (use_rs2 && (ex_rd == rs2)));

    assign unused_bits = ^{id_instr[N-1:25], id_instr[14:7]};

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: memory wait, branch redirect, load-use
// stall and fetch miss, with saturating stall/flush counters.
//
//   state  | meaning
//   RUN    | normal flow, all hazards evaluated in priority order
//   LSTALL | extra load-use stall cycles (LOAD_LAT > 1)
//   MWAIT  | data memory busy, back end frozen
//   REDIR  | one cycle to discard the wrong-path fetch after a taken branch
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int N        = 32,
    parameter int REGW     = pipe_ctrl_pkg::REGW,
    parameter int LOAD_LAT = 1,
    parameter int CNTW     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave bus
);
    ctrl_state_t     state;
    ctrl_state_t     state_nxt;
    logic [2:0]      lcnt;
    logic [2:0]      lcnt_nxt;
    logic [CNTW-1:0] stall_cnt;
    logic [CNTW-1:0] flush_cnt;
    logic            lu;
    logic            run_eval;
    logic            mem_ok;
    logic            pc_write;
    logic            ifid_write;
    logic            ifid_flush;
    logic            idex_bubble;
    logic            exmem_hold;

    hazard_decode #(.N(N), .REGW(REGW)) u_hazard_decode (
        .id_instr   (bus.id_instr),
        .ex_memread (bus.ex_memread),
        .ex_rd      (bus.ex_rd),
        .lu         (lu)
    );

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_hold  = 1'b0;
        state_nxt   = RUN;
        lcnt_nxt    = lcnt;
        run_eval    = 1'b0;
        mem_ok      = 1'b1;

        case (state)
            RUN: run_eval = 1'b1;
            MWAIT: begin
                if (bus.dmem_busy) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    exmem_hold = 1'b1;
                    state_nxt  = MWAIT;
                end else begin
                    run_eval = 1'b1;
                    mem_ok   = 1'b0;
                end
            end
            REDIR: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                if (bus.dmem_busy) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    exmem_hold  = 1'b1;
                    idex_bubble = 1'b0;
                    state_nxt   = MWAIT;
                end
            end
            LSTALL: begin
                if (bus.dmem_busy || bus.ex_branch_taken) begin
                    run_eval = 1'b1;
                end else begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    lcnt_nxt    = lcnt - 3'd1;
                    state_nxt   = (lcnt <= 3'd1) ? RUN : LSTALL;
                end
            end
        endcase

        if (run_eval) begin
            if (mem_ok && bus.dmem_busy) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                exmem_hold = 1'b1;
                state_nxt  = MWAIT;
            end else if (bus.ex_branch_taken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                state_nxt   = REDIR;
            end else if (lu) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                if (LOAD_LAT > 1) begin
                    lcnt_nxt  = 3'(LOAD_LAT - 1);
                    state_nxt = LSTALL;
                end
            end else if (!bus.imem_valid) begin
                pc_write   = 1'b0;
                ifid_flush = 1'b1;
            end
        end

        // Hold the whole pipe quiet and filled with NOPs while in reset.
        if (!rst_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_hold  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            lcnt      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            lcnt  <= lcnt_nxt;
            if (!pc_write && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (ifid_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign bus.pc_write    = pc_write;
    assign bus.ifid_write  = ifid_write;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.exmem_hold  = exmem_hold;
    assign bus.stall_cnt   = stall_cnt;
    assign bus.flush_cnt   = flush_cnt;
    assign bus.state       = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three instances (default, LOAD_LAT=3,
// CNTW=4) share one stimulus; control word = {pc_w, ifid_w, flush, bubble, hold}.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam logic [4:0] C_DEF   = 5'b11000;
    localparam logic [4:0] C_LU    = 5'b00010;
    localparam logic [4:0] C_MEM   = 5'b00001;
    localparam logic [4:0] C_BR    = 5'b11110;
    localparam logic [4:0] C_MISS  = 5'b01100;
    localparam logic [4:0] C_RST   = 5'b00110;
    localparam logic [4:0] C_RBUSY = 5'b00101;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] id_instr = NOP;
    logic        ex_memread = 1'b0;
    logic [4:0]  ex_rd = 5'd0;
    logic        ex_branch_taken = 1'b0;
    logic        dmem_busy = 1'b0;
    logic        imem_valid = 1'b1;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.N(32), .REGW(5), .CNTW(16)) bus_a ();
    pipe_hazard_ctrl_if #(.N(32), .REGW(5), .CNTW(16)) bus_l ();
    pipe_hazard_ctrl_if #(.N(32), .REGW(5), .CNTW(4))  bus_s ();

    assign bus_a.id_instr = id_instr;         assign bus_l.id_instr = id_instr;         assign bus_s.id_instr = id_instr;
    assign bus_a.ex_memread = ex_memread;     assign bus_l.ex_memread = ex_memread;     assign bus_s.ex_memread = ex_memread;
    assign bus_a.ex_rd = ex_rd;               assign bus_l.ex_rd = ex_rd;               assign bus_s.ex_rd = ex_rd;
    assign bus_a.ex_branch_taken = ex_branch_taken;
    assign bus_l.ex_branch_taken = ex_branch_taken;
    assign bus_s.ex_branch_taken = ex_branch_taken;
    assign bus_a.dmem_busy = dmem_busy;       assign bus_l.dmem_busy = dmem_busy;       assign bus_s.dmem_busy = dmem_busy;
    assign bus_a.imem_valid = imem_valid;     assign bus_l.imem_valid = imem_valid;     assign bus_s.imem_valid = imem_valid;

    pipe_hazard_ctrl #(.N(32), .REGW(5), .LOAD_LAT(1), .CNTW(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    pipe_hazard_ctrl #(.N(32), .REGW(5), .LOAD_LAT(3), .CNTW(16)) dut_l (.clk(clk), .rst_n(rst_n), .bus(bus_l));
    pipe_hazard_ctrl #(.N(32), .REGW(5), .LOAD_LAT(1), .CNTW(4))  dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

    wire [4:0] ctl_a = {bus_a.pc_write, bus_a.ifid_write, bus_a.ifid_flush, bus_a.idex_bubble, bus_a.exmem_hold};
    wire [4:0] ctl_l = {bus_l.pc_write, bus_l.ifid_write, bus_l.ifid_flush, bus_l.idex_bubble, bus_l.exmem_hold};
    wire [4:0] ctl_s = {bus_s.pc_write, bus_s.ifid_write, bus_s.ifid_flush, bus_s.idex_bubble, bus_s.exmem_hold};

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, op};
    endfunction

    // Drive one cycle of inputs at the falling edge, settle, then return for checks.
    task automatic apply(input logic mr, input logic [4:0] rd, input logic [31:0] ins,
                         input logic br, input logic busy, input logic iv);
        @(negedge clk);
        ex_memread = mr; ex_rd = rd; id_instr = ins;
        ex_branch_taken = br; dmem_busy = busy; imem_valid = iv;
        #1;
    endtask

    task automatic idle();
        apply(1'b0, 5'd0, NOP, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ex_memread = 1'b0; ex_rd = 5'd0; id_instr = NOP;
        ex_branch_taken = 1'b0; dmem_busy = 1'b0; imem_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        ex_branch_taken = 1'b1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (ctl_a !== C_RST) begin n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl_a, C_RST); end
        n_checks++; if (bus_a.state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", bus_a.state); end
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus_a.flush_cnt !== 16'd0 || bus_a.stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_nocount: got stall %0d flush %0d want 0 0", bus_a.stall_cnt, bus_a.flush_cnt);
        end
        @(negedge clk);
        ex_branch_taken = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        do_reset();
        apply(1'b1, 5'd5, mk(OP_R, 5'd1, 5'd5, 5'd2), 1'b0, 1'b0, 1'b1);
        n_checks++; if (ctl_a !== C_LU) begin n_fail++; $display("FAIL lu_rs1_ctl: got %b want %b", ctl_a, C_LU); end
        idle();
        n_checks++; if (ctl_a !== C_DEF) begin n_fail++; $display("FAIL lu_after_ctl: got %b want %b", ctl_a, C_DEF); end
        n_checks++; if (bus_a.stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d want 1", bus_a.stall_cnt); end
        n_checks++; if (bus_a.state !== 2'd0) begin n_fail++; $display("FAIL lu_state: got %0d want 0", bus_a.state); end
        apply(1'b1, 5'd2, mk(OP_R, 5'd1, 5'd5, 5'd2), 1'b0, 1'b0, 1'b1);
        n_checks++; if (ctl_a !== C_LU) begin n_fail++; $display("FAIL lu_rs2_ctl: got %b want %b", ctl_a, C_LU); end
        apply(1'b1, 5'd2, mk(OP_STORE, 5'd0, 5'd7, 5'd2), 1'b0, 1'b0, 1'b1);
        n_checks++; if (ctl_a !== C_LU) begin n_fail++; $display("FAIL lu_store_ctl: got %b want %b", ctl_a, C_LU); end
        apply(1'b1, 5'd2, mk(7'b0010011, 5'd1, 5'd7, 5'd2), 1'b0, 1'b0, 1'b1);
        n_checks++; if (ctl_a !== C_DEF) begin n_fail++; $display("FAIL lu_itype_ctl: got %b want %b", ctl_a, C_DEF); end
        n_checks++; if (bus_a.stall_cnt !== 16'd3) begin n_fail++; $display("FAIL lu_stall_cnt3: got %0d want 3", bus_a.stall_cnt); end
        apply(1'b1, 5'd7, mk(OP_BRANCH, 5'd0, 5'd3, 5'd7), 1'b0, 1'b0, 1'b1);
        n_checks++; if (ctl_a !== C_LU) begin n_fail++; $display("FAIL lu_branch_rs2_ctl: got %b want %b", ctl_a, C_LU); end
        apply(1'b0, 5'd7, mk(OP_BRANCH, 5'd0, 5'd3, 5'd7), 1'b0, 1'b0, 1'b1);
        n_checks++; if (ctl_a !== C_DEF) begin n_fail++; $display("FAIL lu_noload_ctl: got %b want %b", ctl_a, C_DEF); end
    endtask

    task automatic test_exemptions();
        do_reset();
        apply(1'b1, 5'd0, mk(OP_R, 5'd1, 5'd0, 5'd0), 1'b0, 1'b0, 1'b1);
        n_checks++; if (ctl_a !== C_DEF) begin n_fail++; $display("FAIL ex_x0_ctl: got %b want %b", ctl_a, C_DEF); end
        apply(1'b1, 5'd9, mk(OP_LUI, 5'd9, 5'd9, 5'd9), 1'b0, 1'b0, 1'b1);
        n_checks++; if (ctl_a !== C_DEF) begin n_fail++; $display("FAIL ex_lui_ctl: got %b want %b", ctl_a, C_DEF); end
        apply(1'b1, 5'd9, mk(OP_AUIPC, 5'd9, 5'd9, 5'd9), 1'b0, 1'b0, 1'b1);
        n_checks++; if (ctl_a !== C_DEF) begin n_fail++; $display("FAIL ex_auipc_ctl: got %b want %b", ctl_a, C_DEF); end
        apply(1'b1, 5'd9, mk(OP_JAL, 5'd9, 5'd9, 5'd9), 1'b0, 1'b0, 1'b1);
        n_checks++; if (ctl_a !== C_DEF) begin n_fail++; $display("FAIL ex_jal_ctl: got %b want %b", ctl_a, C_DEF); end
        idle();
        n_checks++; if (bus_a.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL ex_stall_cnt: got %0d want 0", bus_a.stall_cnt); end
    endtask

    task automatic test_branch();
        do_reset();
        apply(1'b0, 5'd0, NOP, 1'b1, 1'b0, 1'b1);
        n_checks++; if (ctl_a !== C_BR || bus_a.state !== 2'd0) begin n_fail++; $display("FAIL br_run: got ctl %b st %0d want %b 0", ctl_a, bus_a.state, C_BR); end
        idle();
        n_checks++; if (ctl_a !== C_BR || bus_a.state !== 2'd3) begin n_fail++; $display("FAIL br_redir: got ctl %b st %0d want %b 3", ctl_a, bus_a.state, C_BR); end
        idle();
        n_checks++; if (ctl_a !== C_DEF || bus_a.state !== 2'd0) begin n_fail++; $display("FAIL br_back: got ctl %b st %0d want %b 0", ctl_a, bus_a.state, C_DEF); end
        n_checks++; if (bus_a.flush_cnt !== 16'd2) begin n_fail++; $display("FAIL br_flush_cnt: got %0d want 2", bus_a.flush_cnt); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 5'd0, NOP, 1'b1, 1'b1, 1'b1);
            n_checks++; if (ctl_a !== C_MEM || bus_a.state !== ((i == 0) ? 2'd0 : 2'd2)) begin
                n_fail++; $display("FAIL mw_busy%0d: got ctl %b st %0d want %b %0d", i, ctl_a, bus_a.state, C_MEM, (i == 0) ? 0 : 2);
            end
        end
        apply(1'b0, 5'd0, NOP, 1'b1, 1'b0, 1'b1);
        n_checks++; if (ctl_a !== C_BR || bus_a.state !== 2'd2) begin n_fail++; $display("FAIL mw_release: got ctl %b st %0d want %b 2", ctl_a, bus_a.state, C_BR); end
        idle();
        n_checks++; if (ctl_a !== C_BR || bus_a.state !== 2'd3) begin n_fail++; $display("FAIL mw_redir: got ctl %b st %0d want %b 3", ctl_a, bus_a.state, C_BR); end
        n_checks++; if (bus_a.stall_cnt !== 16'd4 || bus_a.flush_cnt !== 16'd1) begin
            n_fail++; $display("FAIL mw_counts: got stall %0d flush %0d want 4 1", bus_a.stall_cnt, bus_a.flush_cnt);
        end
        idle();
        n_checks++; if (bus_a.state !== 2'd0 || bus_a.flush_cnt !== 16'd2) begin
            n_fail++; $display("FAIL mw_end: got st %0d flush %0d want 0 2", bus_a.state, bus_a.flush_cnt);
        end
    endtask

    task automatic test_redir_busy();
        do_reset();
        apply(1'b0, 5'd0, NOP, 1'b1, 1'b0, 1'b1);
        apply(1'b0, 5'd0, NOP, 1'b0, 1'b1, 1'b1);
        n_checks++; if (ctl_a !== C_RBUSY || bus_a.state !== 2'd3) begin n_fail++; $display("FAIL rb_redir: got ctl %b st %0d want %b 3", ctl_a, bus_a.state, C_RBUSY); end
        apply(1'b0, 5'd0, NOP, 1'b0, 1'b1, 1'b1);
        n_checks++; if (ctl_a !== C_MEM || bus_a.state !== 2'd2) begin n_fail++; $display("FAIL rb_mwait: got ctl %b st %0d want %b 2", ctl_a, bus_a.state, C_MEM); end
        n_checks++; if (bus_a.flush_cnt !== 16'd2) begin n_fail++; $display("FAIL rb_flush_cnt: got %0d want 2", bus_a.flush_cnt); end
        idle();
        n_checks++; if (ctl_a !== C_DEF || bus_a.state !== 2'd2) begin n_fail++; $display("FAIL rb_release: got ctl %b st %0d want %b 2", ctl_a, bus_a.state, C_DEF); end
        idle();
        n_checks++; if (bus_a.state !== 2'd0) begin n_fail++; $display("FAIL rb_end: got st %0d want 0", bus_a.state); end
    endtask

    task automatic test_lstall();
        logic [31:0] ins;
        logic [1:0]  exp_st [3];
        ins = mk(OP_R, 5'd1, 5'd5, 5'd2);
        exp_st[0] = 2'd0; exp_st[1] = 2'd1; exp_st[2] = 2'd1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 5'd5, ins, 1'b0, 1'b0, 1'b1);
            n_checks++; if (ctl_l !== C_LU || bus_l.state !== exp_st[i]) begin
                n_fail++; $display("FAIL ls_cycle%0d: got ctl %b st %0d want %b %0d", i, ctl_l, bus_l.state, C_LU, exp_st[i]);
            end
        end
        idle();
        n_checks++; if (ctl_l !== C_DEF || bus_l.state !== 2'd0) begin n_fail++; $display("FAIL ls_done: got ctl %b st %0d want %b 0", ctl_l, bus_l.state, C_DEF); end
        n_checks++; if (bus_l.stall_cnt !== 16'd3) begin n_fail++; $display("FAIL ls_stall_cnt: got %0d want 3", bus_l.stall_cnt); end

        do_reset();
        apply(1'b1, 5'd5, ins, 1'b0, 1'b0, 1'b1);
        apply(1'b1, 5'd5, ins, 1'b0, 1'b0, 1'b1);
        n_checks++; if (bus_l.state !== 2'd1 || bus_l.stall_cnt !== 16'd1) begin
            n_fail++; $display("FAIL ls_pre_rst: got st %0d stall %0d want 1 1", bus_l.state, bus_l.stall_cnt);
        end
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus_l.state !== 2'd0 || bus_l.stall_cnt !== 16'd0 || bus_l.flush_cnt !== 16'd0) begin
            n_fail++; $display("FAIL ls_mid_rst: got st %0d stall %0d flush %0d want 0 0 0", bus_l.state, bus_l.stall_cnt, bus_l.flush_cnt);
        end
        n_checks++; if (ctl_l !== C_RST) begin n_fail++; $display("FAIL ls_rst_ctl: got %b want %b", ctl_l, C_RST); end
        @(negedge clk);
        rst_n = 1'b1;

        do_reset();
        apply(1'b1, 5'd5, ins, 1'b0, 1'b0, 1'b1);
        apply(1'b1, 5'd5, ins, 1'b0, 1'b1, 1'b1);
        n_checks++; if (ctl_l !== C_MEM || bus_l.state !== 2'd1) begin n_fail++; $display("FAIL ls_abort: got ctl %b st %0d want %b 1", ctl_l, bus_l.state, C_MEM); end
        idle();
        n_checks++; if (ctl_l !== C_DEF || bus_l.state !== 2'd2) begin n_fail++; $display("FAIL ls_abort_mw: got ctl %b st %0d want %b 2", ctl_l, bus_l.state, C_DEF); end
    endtask

    task automatic test_saturation();
        logic [3:0] exp_cnt;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            apply(1'b0, 5'd0, NOP, 1'b0, 1'b0, 1'b0);
            exp_cnt = (i > 15) ? 4'd15 : 4'(i);
            n_checks++; if (ctl_s !== C_MISS || bus_s.stall_cnt !== exp_cnt || bus_s.flush_cnt !== exp_cnt) begin
                n_fail++; $display("FAIL sat_cycle%0d: got ctl %b stall %0d flush %0d want %b %0d %0d",
                                   i, ctl_s, bus_s.stall_cnt, bus_s.flush_cnt, C_MISS, exp_cnt, exp_cnt);
            end
        end
        idle();
        n_checks++; if (bus_s.stall_cnt !== 4'd15 || bus_s.flush_cnt !== 4'd15) begin
            n_fail++; $display("FAIL sat_final: got stall %0d flush %0d want 15 15", bus_s.stall_cnt, bus_s.flush_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_exemptions();
        test_branch();
        test_mem_wait();
        test_redir_busy();
        test_lstall();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
